// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state memory responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int WORD_BYTES = 4;
   localparam int WORD_SHIFT = $clog2(WORD_BYTES);
   localparam int WAIT_W     = 4;

   // Misaligned, below the base, or past the last word of the array.
   function automatic logic addr_err(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned depth_log2);
      logic [31:0] off;
      off = adr - base;
      return (adr[WORD_SHIFT-1:0] != '0) || (adr < base) ||
             ((off >> WORD_SHIFT) >= (32'd1 << depth_log2));
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read at the presented index.
module mem_array #(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] idx_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[idx_i] <= wdata_i;
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_wait_responder.sv
// Single-outstanding memory responder with programmable wait states and
// error reporting for misaligned or unmapped word accesses.
module mem_wait_responder
   import mem_resp_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 6,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemErr,
   output logic        Busy
);

   state_e                state_q;
   logic [WAIT_W-1:0]     cnt_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [31:0]           wdata_q;
   logic                  write_q;
   logic                  err_q;
   logic [31:0]           rdata_q;
   logic                  ready_q;
   logic                  merr_q;
   logic                  busy_q;

   logic                  accept;
   logic                  in_err;
   logic [DEPTH_LOG2-1:0] in_idx;
   logic [DEPTH_LOG2-1:0] idx_d;
   logic [31:0]           wdata_d;
   logic                  write_d;
   logic                  err_d;
   logic                  enter_resp;
   logic                  arr_we;
   logic                  load_d;
   logic [31:0]           arr_rdata;

   assign accept = (state_q == IDLE) && MemReq;
   assign in_err = addr_err(Adr, BASE_ADDR, DEPTH_LOG2);
   assign in_idx = DEPTH_LOG2'((Adr - BASE_ADDR) >> WORD_SHIFT);

   // In IDLE the live request drives the array so a zero-wait access can
   // complete on the accepting edge; otherwise the latched copy is used.
   always_comb begin
      idx_d   = idx_q;
      wdata_d = wdata_q;
      write_d = write_q;
      err_d   = err_q;
      if (state_q == IDLE) begin
         idx_d   = in_idx;
         wdata_d = WriteData;
         write_d = MemWrite;
         err_d   = in_err;
      end
   end

   assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                       ((state_q == BUSY) && (cnt_q == '0));
   // Reset on the edge into RESP drops the store.
   assign arr_we = enter_resp && write_d && !err_d && !reset;
   assign load_d = enter_resp && !write_d && !err_d;

   mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .idx_i   (idx_d),
      .wdata_i (wdata_d),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         merr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         merr_q  <= 1'b0;
         if (accept) begin
            idx_q   <= in_idx;
            wdata_q <= WriteData;
            write_q <= MemWrite;
            err_q   <= in_err;
         end
         if (load_d) rdata_q <= arr_rdata;
         if (enter_resp) begin
            ready_q <= 1'b1;
            merr_q  <= err_d;
         end
         case (state_q)
            IDLE: begin
               if (MemReq) begin
                  busy_q <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= WAIT_W'(WAIT_CYCLES - 1);
                  end
               end
            end
            BUSY: begin
               if (cnt_q == '0) state_q <= RESP;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ReadData = rdata_q;
   assign MemReady = ready_q;
   assign MemErr   = merr_q;
   assign Busy     = busy_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for three responder configurations, checked every cycle
// against a transaction-level model plus hand-computed literal expectations.
module tb_mem_wait_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [3];
   logic        req   [3];
   logic [31:0] adr   [3];
   logic [31:0] wd    [3];
   logic        mw    [3];
   logic [31:0] rdata [3];
   logic        rdy   [3];
   logic        merr  [3];
   logic        busy  [3];

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   mem_wait_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_w2 (
      .clk(clk), .reset(rst[0]), .MemReq(req[0]), .Adr(adr[0]), .WriteData(wd[0]),
      .MemWrite(mw[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .MemErr(merr[0]), .Busy(busy[0]));
   mem_wait_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
      .clk(clk), .reset(rst[1]), .MemReq(req[1]), .Adr(adr[1]), .WriteData(wd[1]),
      .MemWrite(mw[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .MemErr(merr[1]), .Busy(busy[1]));
   mem_wait_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(1), .BASE_ADDR(32'h100)) u_b1 (
      .clk(clk), .reset(rst[2]), .MemReq(req[2]), .Adr(adr[2]), .WriteData(wd[2]),
      .MemWrite(mw[2]), .ReadData(rdata[2]), .MemReady(rdy[2]), .MemErr(merr[2]), .Busy(busy[2]));

   function automatic int wt(int i);
      case (i)
         0:       return 2;
         1:       return 0;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] base_of(int i);
      return (i == 2) ? 32'h100 : 32'h0;
   endfunction

   function automatic longint offs(int i, logic [31:0] a);
      return longint'({32'h0, a}) - longint'({32'h0, base_of(i)});
   endfunction

   function automatic bit bad(int i, logic [31:0] a);
      return (a % 4 != 0) || (offs(i, a) < 0) || (offs(i, a) / 4 >= 64);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a request waits W+1 edges for its response; memory is a sparse map.
   int          t_left [3];
   logic [31:0] p_adr  [3];
   logic [31:0] p_wd   [3];
   bit          p_we   [3];
   logic [31:0] e_rd   [3];
   bit          e_rdy  [3];
   bit          e_err  [3];
   bit          e_busy [3];
   logic [31:0] mmem   [int];
   bit          m_idle;
   int          m_key;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst[i]) begin
            t_left[i] = 0; e_rd[i] = '0; e_rdy[i] = 0; e_err[i] = 0; e_busy[i] = 0;
         end else begin
            m_idle = (t_left[i] == 0);
            if (t_left[i] > 0) t_left[i]--;
            if (m_idle && req[i]) begin
               t_left[i] = wt(i) + 1;
               p_adr[i] = adr[i]; p_wd[i] = wd[i]; p_we[i] = mw[i];
            end
            e_busy[i] = (t_left[i] > 0);
            e_rdy[i]  = (t_left[i] == 1);
            e_err[i]  = 0;
            if (e_rdy[i]) begin
               if (bad(i, p_adr[i])) e_err[i] = 1;
               else begin
                  m_key = i * 1000 + int'(offs(i, p_adr[i]) / 4);
                  if (p_we[i]) mmem[m_key] = p_wd[i];
                  else e_rd[i] = mmem.exists(m_key) ? mmem[m_key] : 32'hxxxx_xxxx;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.MemReady", i), {31'b0, rdy[i]},  {31'b0, e_rdy[i]});
            chk($sformatf("u%0d.MemErr", i),   {31'b0, merr[i]}, {31'b0, e_err[i]});
            chk($sformatf("u%0d.Busy", i),     {31'b0, busy[i]}, {31'b0, e_busy[i]});
            chk($sformatf("u%0d.ReadData", i), rdata[i], e_rd[i]);
         end
      end
   end

   // One-cycle request; fields are scrambled afterwards to prove they were latched.
   task automatic issue(int i, bit w, logic [31:0] a, logic [31:0] d);
      @(negedge clk);
      req[i] = 1'b1; mw[i] = w; adr[i] = a; wd[i] = d;
      @(negedge clk);
      req[i] = 1'b0; mw[i] = ~w; adr[i] = ~a; wd[i] = ~d;
   endtask

   task automatic wait_ready(int i, int lat, bit err, bit chk_rd, logic [31:0] rd, string name);
      int n = 1;
      while (!rdy[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[i]) begin
         vectors++; miscompares++;
         $display("FAIL %s: no MemReady within %0d cycles", name, n);
      end else begin
         chk({name, ".latency"}, 32'(n), 32'(lat));
         chk({name, ".err"}, {31'b0, merr[i]}, {31'b0, err});
         if (chk_rd) chk({name, ".data"}, rdata[i], rd);
      end
   endtask

   function automatic logic [31:0] bb_data(int i, logic [31:0] a);
      return 32'hB0B0_0000 | (32'(i) << 12) | a;
   endfunction

   task automatic back_to_back(int i);
      logic [31:0] seq [5];
      int w;
      w = wt(i);
      seq = '{32'h4, 32'h8, 32'hC, 32'h4, 32'h8};
      for (int j = 1; j < 4; j++) begin
         issue(i, 1'b1, seq[j-1], bb_data(i, seq[j-1]));
         wait_ready(i, w + 1, 1'b0, 1'b0, '0, $sformatf("u%0d.bbfill%0d", i, j));
      end
      @(negedge clk);
      req[i] = 1'b1; mw[i] = 1'b0;
      for (int j = 0; j < 5; j++) begin
         adr[i] = seq[j];
         for (int n = 1; n <= w + 2; n++) begin
            @(negedge clk);
            chk($sformatf("u%0d.bb%0d.ready@%0d", i, j, n), {31'b0, rdy[i]}, {31'b0, n == w + 1});
            if (n == w + 1) chk($sformatf("u%0d.bb%0d.data", i, j), rdata[i], bb_data(i, seq[j]));
         end
      end
      req[i] = 1'b0;
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req[i] = 1'b0; adr[i] = '0; wd[i] = '0; mw[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.reset.ready", i), {31'b0, rdy[i]}, 32'h0);
         chk($sformatf("u%0d.reset.busy", i),  {31'b0, busy[i]}, 32'h0);
         chk($sformatf("u%0d.reset.rdata", i), rdata[i], 32'h0);
      end

      // WAIT_CYCLES=2: store/load, misaligned, out-of-range
      issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      wait_ready(0, 3, 1'b0, 1'b0, '0, "w2.store10");
      issue(0, 1'b0, 32'h10, 32'h0);
      wait_ready(0, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, "w2.load10");
      issue(0, 1'b0, 32'h13, 32'h0);
      wait_ready(0, 3, 1'b1, 1'b1, 32'hDEAD_BEEF, "w2.misaligned");
      issue(0, 1'b1, 32'h0, 32'h0BAD_F00D);
      wait_ready(0, 3, 1'b0, 1'b0, '0, "w2.store0");
      issue(0, 1'b1, 32'h100, 32'h7777_7777);
      wait_ready(0, 3, 1'b1, 1'b1, 32'hDEAD_BEEF, "w2.store100");
      issue(0, 1'b0, 32'h0, 32'h0);
      wait_ready(0, 3, 1'b0, 1'b1, 32'h0BAD_F00D, "w2.load0");

      // Request during BUSY is dropped
      issue(0, 1'b1, 32'h20, 32'h2020_2020);
      wait_ready(0, 3, 1'b0, 1'b0, '0, "w2.store20");
      issue(0, 1'b0, 32'h10, 32'h0);
      req[0] = 1'b1; mw[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'h5555_0000;
      @(negedge clk);
      req[0] = 1'b0;
      pulses = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (rdy[0]) begin
            pulses++;
            chk("w2.ignored.busy_in_resp", {31'b0, busy[0]}, 32'h1);
         end
      end
      chk("w2.ignored.pulses", 32'(pulses), 32'd1);
      issue(0, 1'b0, 32'h20, 32'h0);
      wait_ready(0, 3, 1'b0, 1'b1, 32'h2020_2020, "w2.load20");

      // Reset lands on the edge that would enter RESP
      issue(0, 1'b1, 32'h8, 32'h1111_2222);
      wait_ready(0, 3, 1'b0, 1'b0, '0, "w2.store8");
      issue(0, 1'b1, 32'h8, 32'hAAAA_5555);
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("w2.midreset.ready", {31'b0, rdy[0]}, 32'h0);
      chk("w2.midreset.err",   {31'b0, merr[0]}, 32'h0);
      chk("w2.midreset.busy",  {31'b0, busy[0]}, 32'h0);
      chk("w2.midreset.rdata", rdata[0], 32'h0);
      repeat (4) @(negedge clk);
      issue(0, 1'b0, 32'h8, 32'h0);
      wait_ready(0, 3, 1'b0, 1'b1, 32'h1111_2222, "w2.load8");
      back_to_back(0);

      // WAIT_CYCLES=0
      issue(1, 1'b1, 32'h0, 32'h1234_5678);
      wait_ready(1, 1, 1'b0, 1'b0, '0, "w0.store0");
      issue(1, 1'b0, 32'h0, 32'h0);
      wait_ready(1, 1, 1'b0, 1'b1, 32'h1234_5678, "w0.load0");
      back_to_back(1);

      // WAIT_CYCLES=1, BASE_ADDR=0x100: both range edges
      issue(2, 1'b1, 32'hFC, 32'h0);
      wait_ready(2, 2, 1'b1, 1'b1, 32'h0, "b1.belowbase");
      issue(2, 1'b1, 32'h100, 32'hCAFE_0001);
      wait_ready(2, 2, 1'b0, 1'b0, '0, "b1.store100");
      issue(2, 1'b1, 32'h1FC, 32'hCAFE_0002);
      wait_ready(2, 2, 1'b0, 1'b0, '0, "b1.store1FC");
      issue(2, 1'b0, 32'h200, 32'h0);
      wait_ready(2, 2, 1'b1, 1'b1, 32'h0, "b1.load200");
      issue(2, 1'b0, 32'h100, 32'h0);
      wait_ready(2, 2, 1'b0, 1'b1, 32'hCAFE_0001, "b1.load100");
      issue(2, 1'b0, 32'h1FC, 32'h0);
      wait_ready(2, 2, 1'b0, 1'b1, 32'hCAFE_0002, "b1.load1FC");
      issue(2, 1'b0, 32'h0, 32'h0);
      wait_ready(2, 2, 1'b1, 1'b1, 32'hCAFE_0002, "b1.load0");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
